// File: rtl/serie_paralelo_pkg.sv
// Shared definitions for the serial link: FSM state encoding and the default
// word length that both the transmitter and this receiver agree on.
package serie_paralelo_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 6;

endpackage

// File: rtl/serie_paralelo.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words from a bit stream
// qualified by ena_in, strobes ena_out per word and err per truncated frame.
module serie_paralelo
    import serie_paralelo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ena_in,
    input  logic             in,
    output logic [WIDTH-1:0] out,
    output logic             ena_out,
    output logic             err,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    // Handshake: ena_in=1 means `in` carries a valid bit this cycle; there is no
    // back-pressure, every valid bit is consumed on the rising edge.

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] w_sh_next;
    logic [WIDTH-1:0] r_out;
    logic             r_ena_out;
    logic             r_err;
    logic             w_shift;
    logic             w_load_out;
    logic             w_err_next;

    generate
        if (MSB_FIRST) begin : g_msb
            assign w_sh_next = {r_sh[WIDTH-2:0], in};
        end else begin : g_lsb
            assign w_sh_next = {in, r_sh[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_shift      = 1'b0;
        w_load_out   = 1'b0;
        w_err_next   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ena_in) begin
                    w_shift      = 1'b1;
                    w_cnt_next   = CNT_W'(1);
                    w_state_next = ST_RECV;
                end
            end
            ST_RECV: begin
                if (!ena_in) begin
                    // Frame truncated: drop the partial word, keep the last good out.
                    w_err_next   = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = ST_IDLE;
                end else if (r_cnt == LAST_BIT) begin
                    w_shift      = 1'b1;
                    w_load_out   = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = ST_IDLE;
                end else begin
                    w_shift    = 1'b1;
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_sh      <= '0;
            r_out     <= '0;
            r_ena_out <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (w_shift) begin
                r_sh <= w_sh_next;
            end
            // The final bit goes straight into out alongside the shift register.
            if (w_load_out) begin
                r_out <= w_sh_next;
            end
            r_ena_out <= w_load_out;
            r_err     <= w_err_next;
        end
    end

    assign out     = r_out;
    assign ena_out = r_ena_out;
    assign err     = r_err;
    assign busy    = (r_state == ST_RECV);

endmodule

// File: tb/tb_serie_paralelo.sv
// Bench for serie_paralelo: MSB-first and LSB-first instances share one stimulus
// stream and are compared every cycle against a bit-list model of the link.
module tb_serie_paralelo;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         clr = 1'b1;
    logic         ena_in = 1'b0;
    logic         in_b = 1'b0;
    logic [W-1:0] out_m, out_l;
    logic         ena_out_m, ena_out_l, err_m, err_l, busy_m, busy_l;

    serie_paralelo #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .clr(clr), .ena_in(ena_in), .in(in_b),
        .out(out_m), .ena_out(ena_out_m), .err(err_m), .busy(busy_m)
    );

    serie_paralelo #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .clr(clr), .ena_in(ena_in), .in(in_b),
        .out(out_l), .ena_out(ena_out_l), .err(err_l), .busy(busy_l)
    );

    // clock / reset
    always #5 clk = ~clk;

    // model state and counters
    int           n_cmp = 0;
    int           n_err = 0;
    bit           checking = 1'b0;
    int           bits_q[$];
    logic [W-1:0] exp_out_m = '0;
    logic [W-1:0] exp_out_l = '0;
    logic         exp_ena_out = 1'b0;
    logic         exp_err = 1'b0;
    logic         exp_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        bits_q.delete();
        exp_out_m   = '0;
        exp_out_l   = '0;
        exp_ena_out = 1'b0;
        exp_err     = 1'b0;
        exp_busy    = 1'b0;
    endtask

    // One sampled edge: collect bits into a list; a full list becomes a word
    // read in both bit orders, a gap in a non-empty list is an aborted frame.
    task automatic model_step(input logic e, input logic b);
        int wm, wl;
        exp_ena_out = 1'b0;
        exp_err     = 1'b0;
        if (e) begin
            bits_q.push_back(int'(b));
            if (bits_q.size() == W) begin
                wm = 0;
                wl = 0;
                for (int i = 0; i < W; i++) begin
                    wm += bits_q[i] * (1 << (W - 1 - i));
                    wl += bits_q[i] * (1 << i);
                end
                exp_out_m   = W'(wm);
                exp_out_l   = W'(wl);
                exp_ena_out = 1'b1;
                bits_q.delete();
            end
        end else if (bits_q.size() != 0) begin
            exp_err = 1'b1;
            bits_q.delete();
        end
        exp_busy = (bits_q.size() != 0);
    endtask

    // driver tasks
    task automatic cycle(input logic e, input logic b);
        ena_in = e;
        in_b   = b;
        @(posedge clk);
        if (!clr) model_step(e, b);
        @(negedge clk);
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, w[W-1-i]);
    endtask

    task automatic do_reset();
        ena_in = 1'b0;
        #1;
        clr = 1'b1;
        model_reset();
        @(negedge clk);
        check("rst_out", 32'(out_m), 32'h0);
        check("rst_busy", 32'(busy_m), 32'h0);
        check("rst_err", 32'(err_m), 32'h0);
        @(negedge clk);
        clr = 1'b0;
    endtask

    // scoreboard: compare every cycle
    always @(negedge clk) begin
        if (checking) begin
            check("out_msb", 32'(out_m), 32'(exp_out_m));
            check("out_lsb", 32'(out_l), 32'(exp_out_l));
            check("ena_out_msb", 32'(ena_out_m), 32'(exp_ena_out));
            check("ena_out_lsb", 32'(ena_out_l), 32'(exp_ena_out));
            check("err_msb", 32'(err_m), 32'(exp_err));
            check("err_lsb", 32'(err_l), 32'(exp_err));
            check("busy_msb", 32'(busy_m), 32'(exp_busy));
            check("busy_lsb", 32'(busy_l), 32'(exp_busy));
        end
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        checking = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        cycle(1'b0, 1'b0);

        // single word 1,0,1,1,0,1
        send_bits(6'b101101, 6);
        check("single_out", 32'(out_m), 32'h2D);
        check("single_ena", 32'(ena_out_m), 32'h1);
        check("single_busy", 32'(busy_m), 32'h0);
        check("lsb_single_out", 32'(out_l), 32'h2D);
        cycle(1'b0, 1'b0);
        check("single_ena_drop", 32'(ena_out_m), 32'h0);

        // back-to-back, no gap cycle
        send_bits(6'h2D, 6);
        check("b2b_first", 32'(out_m), 32'h2D);
        check("b2b_first_ena", 32'(ena_out_m), 32'h1);
        send_bits(6'h12, 5);
        check("b2b_mid_ena", 32'(ena_out_m), 32'h0);
        check("b2b_mid_busy", 32'(busy_m), 32'h1);
        send_bits(6'h12 << 5, 1);
        check("b2b_second", 32'(out_m), 32'h12);
        check("b2b_second_ena", 32'(ena_out_m), 32'h1);

        // abort after 3 bits
        send_bits(6'b110000, 3);
        cycle(1'b0, 1'b0);
        check("abort_err", 32'(err_m), 32'h1);
        check("abort_ena", 32'(ena_out_m), 32'h0);
        check("abort_out_kept", 32'(out_m), 32'h12);
        cycle(1'b0, 1'b0);
        check("abort_err_drop", 32'(err_m), 32'h0);

        // word after abort; LSB instance sees the reversed value
        send_bits(6'h38, 6);
        check("post_abort_out", 32'(out_m), 32'h38);
        check("post_abort_lsb", 32'(out_l), 32'h07);

        // reset mid-word
        send_bits(6'h15, 4);
        do_reset();
        send_bits(6'h2A, 6);
        check("post_rst_out", 32'(out_m), 32'h2A);
        check("post_rst_lsb", 32'(out_l), 32'h15);

        // randomized stream with gaps and occasional resets
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            cycle(logic'($urandom_range(0, 99) < 85), logic'($urandom_range(0, 1)));
        end
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
